// File: rtl/keypad_lock_ctrl.sv
// Digital-lock entry controller: debounces keypad scanner codes on a slow tick,
// assembles an NDIG-digit code and runs the check/open/lockout sequence.
module keypad_lock_ctrl #(
    parameter int NDIG       = 4,
    parameter int TICK_DIV   = 12500,
    parameter int DEB        = 4,
    parameter int MAX_FAIL   = 3,
    parameter int OPEN_TICKS = 2000,
    parameter int LOCK_TICKS = 8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key_data,
    input  logic              key_star,
    input  logic              key_hash,
    input  logic [4*NDIG-1:0] secret,
    output logic [4*NDIG-1:0] entry,
    output logic [2:0]        digit_cnt,
    output logic              unlock,
    output logic              fail_pulse,
    output logic              locked,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam int          SW         = $clog2(DEB + 1);
    localparam logic [15:0] TICK_MAX   = 16'(TICK_DIV - 1);
    localparam logic [15:0] OPEN_MAX   = 16'(OPEN_TICKS - 1);
    localparam logic [15:0] LOCK_MAX   = 16'(LOCK_TICKS - 1);
    localparam logic [SW-1:0] DEB_C    = SW'(DEB);
    localparam logic [SW-1:0] DEB_M1   = SW'(DEB - 1);
    localparam logic [2:0]  NDIG_C     = 3'(NDIG);
    localparam logic [2:0]  MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [3:0]  CODE_STAR  = 4'hE;
    localparam logic [3:0]  CODE_HASH  = 4'hF;

    logic [15:0]       r_tick_cnt;
    logic              w_tick;
    logic [3:0]        w_raw;
    logic [3:0]        r_cand;
    logic [SW-1:0]     r_stab;
    logic              r_armed;
    logic              w_settle;
    logic              w_event;

    state_t            r_state, w_state_nxt;
    logic [4*NDIG-1:0] r_entry, w_entry_nxt;
    logic [2:0]        r_digit_cnt, w_cnt_nxt;
    logic [2:0]        r_fail_cnt, w_fail_nxt, w_fail_inc;
    logic [15:0]       r_timer, w_timer_nxt;
    logic              w_fail_pulse;
    logic              w_is_digit;
    logic              w_match;

    assign w_tick = (r_tick_cnt == TICK_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    always_comb begin
        w_raw = key_data;
        if (key_star)      w_raw = CODE_STAR;
        else if (key_hash) w_raw = CODE_HASH;
    end

    // The event fires on the tick where stab steps DEB-1 -> DEB; armed
    // re-arms only after a released (code 0) sample settles the same way.
    assign w_settle = w_tick && (w_raw == r_cand) && (r_stab == DEB_M1);
    assign w_event  = w_settle && (r_cand != 4'h0) && r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand  <= '0;
            r_stab  <= '0;
            r_armed <= 1'b0;
        end else if (w_tick) begin
            if (w_raw != r_cand) begin
                r_cand <= w_raw;
                r_stab <= '0;
            end else if (r_stab != DEB_C) begin
                r_stab <= r_stab + 1'b1;
            end
            if (w_event)                          r_armed <= 1'b0;
            else if (w_settle && r_cand == 4'h0) r_armed <= 1'b1;
        end
    end

    assign w_is_digit = (r_cand != CODE_STAR) && (r_cand != CODE_HASH);
    assign w_match    = (r_digit_cnt == NDIG_C) && (r_entry == secret);
    assign w_fail_inc = (r_fail_cnt < MAX_FAIL_C) ? r_fail_cnt + 3'd1 : r_fail_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_entry     <= '0;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_entry     <= w_entry_nxt;
            r_digit_cnt <= w_cnt_nxt;
            r_fail_cnt  <= w_fail_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_entry_nxt  = r_entry;
        w_cnt_nxt    = r_digit_cnt;
        w_fail_nxt   = r_fail_cnt;
        w_timer_nxt  = r_timer;
        w_fail_pulse = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_event && w_is_digit) begin
                    w_entry_nxt = {{(4*NDIG-4){1'b0}}, r_cand};
                    w_cnt_nxt   = 3'd1;
                    w_state_nxt = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (w_event) begin
                    if (r_cand == CODE_STAR) begin
                        w_entry_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else if (r_cand == CODE_HASH) begin
                        w_state_nxt = S_CHECK;
                    end else if (r_digit_cnt < NDIG_C) begin
                        w_entry_nxt = {r_entry[4*NDIG-5:0], r_cand};
                        w_cnt_nxt   = r_digit_cnt + 3'd1;
                    end
                end
            end
            S_CHECK: begin
                w_entry_nxt = '0;
                w_cnt_nxt   = '0;
                w_timer_nxt = '0;
                if (w_match) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = S_OPEN;
                end else begin
                    w_fail_pulse = 1'b1;
                    w_fail_nxt   = w_fail_inc;
                    w_state_nxt  = (w_fail_inc == MAX_FAIL_C) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_OPEN: begin
                if (w_event && r_cand == CODE_STAR) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    if (r_timer == OPEN_MAX) w_state_nxt = S_IDLE;
                    else                     w_timer_nxt = r_timer + 16'd1;
                end
            end
            S_LOCKOUT: begin
                if (w_tick) begin
                    if (r_timer == LOCK_MAX) begin
                        w_fail_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_timer_nxt = r_timer + 16'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign entry      = r_entry;
    assign digit_cnt  = r_digit_cnt;
    assign unlock     = (r_state == S_OPEN);
    assign locked     = (r_state == S_LOCKOUT);
    assign fail_pulse = w_fail_pulse;
    assign state_o    = r_state;

endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
- Sequences the 4x3 keypad scanner output into a digital-lock entry controller.
- Debounces scanner key codes on a slow sample tick and assembles an NDIG-digit code: '*' clears the entry, '#' submits it.
- Compares the submitted entry against a secret, drives unlock and fail indications, and enforces a lockout after repeated failures.
- Sits between keypad_scan (upstream) and the display/actuator logic (downstream).

Parameters:
- NDIG, 4: digits per code.
- TICK_DIV, 12500: clk cycles per sample tick.
- DEB, 4: consecutive identical samples needed to accept a press or a release.
- MAX_FAIL, 3: consecutive wrong submissions that trigger lockout.
- OPEN_TICKS, 2000: ticks unlock stays high.
- LOCK_TICKS, 8000: ticks lockout lasts.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- key_data  in  4  scanner digit code, 1..9; 0 = no digit key.
- key_star  in  1  '*' held.
- key_hash  in  1  '#' held.
- secret  in  4*NDIG  stored code; most significant nibble is the first digit.
- entry  out  4*NDIG  digits typed so far, right-aligned.
- digit_cnt  out  3  number of digits held, 0..NDIG.
- unlock  out  1  high while in OPEN.
- fail_pulse  out  1  one-clk pulse per wrong submission.
- locked  out  1  high while in LOCKOUT.
- state_o  out  3  FSM state: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4.

Behaviour:
- Reset values: all outputs 0 and state IDLE. Internal state also clears: tick counter, debounce, fail_cnt and timers. Reset is honoured mid-operation in any state.
- Tick generation:
  - 16-bit counter runs 0..TICK_DIV-1; tick is a 1-clk pulse when the counter equals TICK_DIV-1, after which it wraps to 0.
  - All debounce logic and timers advance only on tick.
- Raw code priority: key_star gives 4'hE; otherwise key_hash gives 4'hF; otherwise key_data. Raw 0 means released.
- Debounce, on each tick:
  - If raw differs from cand: cand<=raw and stab<=0.
  - Otherwise stab increments, saturating at DEB.
  - A press event fires when stab reaches DEB-1→DEB with cand≠0 and armed=1; armed then clears.
  - armed sets when stab reaches DEB with cand=0.
  - One event per physical press. Holding a key never repeats, and a change between two nonzero codes fires nothing until a release is seen.
  - The event is a 1-clk pulse coincident with the tick.
- FSM, acting on events:
  - IDLE:
    - digit d: entry<=d, digit_cnt<=1, go to ENTRY.
    - '*' or '#': ignored.
  - ENTRY:
    - digit: if digit_cnt<NDIG, entry<={entry[4*NDIG-5:0],d} and digit_cnt+1; otherwise ignored (no overwrite).
    - '*': entry<=0, digit_cnt<=0, go to IDLE.
    - '#': go to CHECK.
  - CHECK (exactly 1 clk):
    - Match = (digit_cnt==NDIG) && (entry==secret).
    - On match: fail_cnt<=0, timer<=0, go to OPEN.
    - On mismatch: fail_pulse=1 this cycle and fail_cnt+1. If the new fail_cnt equals MAX_FAIL, go to LOCKOUT with timer<=0; otherwise go to IDLE.
    - Leaving CHECK always clears entry and digit_cnt.
  - OPEN:
    - unlock=1; timer counts ticks.
    - When timer reaches OPEN_TICKS-1 on a tick, go to IDLE.
    - '*' returns to IDLE immediately; digits and '#' are ignored.
  - LOCKOUT:
    - locked=1; all events discarded, though debounce keeps running.
    - When timer reaches LOCK_TICKS-1 on a tick: fail_cnt<=0, go to IDLE.
- A successful unlock clears fail_cnt, so failures count only when consecutive.
- A tick or event arriving in the CHECK cycle is dropped. Events cannot arrive then in practice, because CHECK follows an event tick.
- fail_cnt is 3 bits and is not incremented beyond MAX_FAIL.
- secret is sampled only in CHECK and may change at any other time.

Test Plan:
Bench uses TICK_DIV=2, DEB=2, OPEN_TICKS=5, LOCK_TICKS=6 and secret=16'h1234; each key is held 4 ticks and released 4 ticks.
- Reset: hold rst=0 mid-ENTRY -> entry=0, digit_cnt=0, unlock=0, locked=0, state_o=0; after release, the first digit is accepted normally.
- Correct code: keys 1,2,3,4,# -> entry=16'h1234 before '#'. unlock=1 for exactly 5 ticks, then state_o=0 with fail_cnt still 0.
- Debounce: key 5 glitching for 1 tick, then 1 held for 10 ticks -> a single digit 1 accepted (digit_cnt=1). Changing 1→2 without release -> no second event.
- Overflow and clear: 1,2,3,4,5 -> entry=16'h1234 and digit_cnt=4. Then '*' -> entry=0, state_o=0.
- Short entry: 1,2,# -> fail_pulse asserted for 1 clk, state_o=0.
- Lockout: three wrong codes (e.g. 9,9,9,9,#) -> third fail gives locked=1 for 6 ticks. Keys pressed during lockout are ignored; afterwards 1,2,3,4,# unlocks.
